// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_scan_driver_if : nibble inputs and display outputs of the scan driver
// Revision 1.0
// ----------------------------------------------------------------------------
interface seg7_scan_driver_if;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] digit_en;
   logic [3:0] dp_in;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] scan_idx;

   modport master (
      output digit0, digit1, digit2, digit3, digit_en, dp_in,
      input  an, seg, dp, scan_idx
   );

   modport slave (
      input  digit0, digit1, digit2, digit3, digit_en, dp_in,
      output an, seg, dp, scan_idx
   );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_scan_driver : 4-digit common-anode 7-segment scanner with blanking
// Revision 1.0
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input wire clk,
   input wire rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int            CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SHOW_START = CW'(BLANK_CYC);

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          wrap;
   logic          capture;
   logic [1:0]    idx;
   logic [3:0]    cur_digit;
   logic [3:0]    hold_val;
   logic          hold_dp;
   logic          hold_en;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      wrap      = (cnt == CNT_LAST);
      cnt_nxt   = wrap ? '0 : cnt + CW'(1);
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         BLANK: begin
            if (cnt_nxt == SHOW_START) begin
               state_nxt = SHOW;
               capture   = 1'b1;
            end
         end
         SHOW: begin
            if (wrap) state_nxt = BLANK;
         end
         default: state_nxt = BLANK;
      endcase
   end

   always_comb begin
      cur_digit = bus.digit0;
      case (idx)
         2'd0: cur_digit = bus.digit0;
         2'd1: cur_digit = bus.digit1;
         2'd2: cur_digit = bus.digit2;
         default: cur_digit = bus.digit3;
      endcase
   end

   // Slot data is frozen at the start of SHOW so switch movement cannot glitch the digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BLANK;
         cnt      <= '0;
         idx      <= 2'd0;
         hold_val <= 4'h0;
         hold_dp  <= 1'b0;
         hold_en  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (wrap) idx <= idx + 2'd1;
         if (capture) begin
            hold_val <= cur_digit;
            hold_dp  <= bus.dp_in[idx];
            hold_en  <= bus.digit_en[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.an  <= 4'b1111;
         bus.seg <= 7'h7F;
         bus.dp  <= 1'b1;
      end else if (state == SHOW && hold_en) begin
         bus.an  <= ~(4'b0001 << idx);
         bus.seg <= hex7(hold_val);
         bus.dp  <= ~hold_dp;
      end else begin
         bus.an  <= 4'b1111;
         bus.seg <= 7'h7F;
         bus.dp  <= 1'b1;
      end
   end

   assign bus.scan_idx = idx;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver : self-checking bench for seg7_scan_driver
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;
   localparam int SD  = 8;
   localparam int BC  = 2;
   localparam int PER = 4 * SD;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_driver_if bus();

   seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] nib;
      logic [6:0] seg;
   } dec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   dec_t tbl [16];
   exp_t sb [$];
   int   checks = 0;
   int   fails  = 0;
   int   e      = 0;   // edges since reset release

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic wait_e(input int v);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (e == v) return;
      end
      chk("wait_e_timeout", e, v);
   endtask

   task automatic wait_mod(input int m);
      for (int k = 0; k < 2 * PER; k++) begin
         @(negedge clk);
         if (e % PER == m) return;
      end
      chk("wait_mod_timeout", e % PER, m);
   endtask

   // Scoreboard: the slot's expected display is queued at its capture edge.
   always @(posedge clk) begin : mon
      int         pos, ph, slot, zeros;
      logic [3:0] nib, one;
      exp_t       x;
      if (!rst_n) begin
         e = 0;
         sb.delete();
         #1;
         chk("rst_an", bus.an, 4'b1111);
         chk("rst_seg", bus.seg, 7'h7F);
         chk("rst_dp", bus.dp, 1'b1);
         chk("rst_idx", bus.scan_idx, 2'd0);
      end else begin
         e++;
         pos  = (e - 1) % PER;
         ph   = pos % SD;
         slot = pos / SD;
         if (ph == BC - 1) begin
            case (slot)
               0: nib = bus.digit0;
               1: nib = bus.digit1;
               2: nib = bus.digit2;
               default: nib = bus.digit3;
            endcase
            one = 4'b0001 << slot;
            if (bus.digit_en[slot]) begin
               x.an  = ~one;
               x.seg = tbl[nib].seg;
               x.dp  = ~bus.dp_in[slot];
            end else begin
               x.an  = 4'b1111;
               x.seg = 7'h7F;
               x.dp  = 1'b1;
            end
            sb.push_back(x);
         end
         #1;
         if (rst_n) begin
            if (ph < BC) begin
               chk("blank_an", bus.an, 4'b1111);
               chk("blank_seg", bus.seg, 7'h7F);
               chk("blank_dp", bus.dp, 1'b1);
            end else begin
               chk("sb_depth", sb.size(), 1);
               if (sb.size() > 0) begin
                  chk("show_an", bus.an, sb[0].an);
                  chk("show_seg", bus.seg, sb[0].seg);
                  chk("show_dp", bus.dp, sb[0].dp);
               end
            end
            chk("scan_idx", bus.scan_idx, (e % PER) / SD);
            zeros = 0;
            for (int i = 0; i < 4; i++) if (!bus.an[i]) zeros++;
            chk("an_onehot", zeros <= 1, 1);
            if (ph == SD - 1 && sb.size() > 0) void'(sb.pop_front());
         end
      end
   end

   initial begin
      tbl[0]  = '{4'h0, 7'h40};  tbl[1]  = '{4'h1, 7'h79};
      tbl[2]  = '{4'h2, 7'h24};  tbl[3]  = '{4'h3, 7'h30};
      tbl[4]  = '{4'h4, 7'h19};  tbl[5]  = '{4'h5, 7'h12};
      tbl[6]  = '{4'h6, 7'h02};  tbl[7]  = '{4'h7, 7'h78};
      tbl[8]  = '{4'h8, 7'h00};  tbl[9]  = '{4'h9, 7'h10};
      tbl[10] = '{4'hA, 7'h08};  tbl[11] = '{4'hB, 7'h03};
      tbl[12] = '{4'hC, 7'h46};  tbl[13] = '{4'hD, 7'h21};
      tbl[14] = '{4'hE, 7'h06};  tbl[15] = '{4'hF, 7'h0E};

      bus.digit0   = 4'h1;
      bus.digit1   = 4'h2;
      bus.digit2   = 4'h3;
      bus.digit3   = 4'h4;
      bus.digit_en = 4'b1111;
      bus.dp_in    = 4'b0000;
      rst_n        = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;

      // Reset release timing and wrap
      wait_e(3);   chk("e3_an", bus.an, 4'b1110); chk("e3_seg", bus.seg, 7'h79);
      wait_e(9);   chk("e9_an", bus.an, 4'b1111);
      wait_e(11);  chk("e11_an", bus.an, 4'b1101); chk("e11_seg", bus.seg, 7'h24);
      wait_e(35);  chk("e35_an", bus.an, 4'b1110);

      // Decode sweep on digit 0
      for (int i = 0; i < 16; i++) begin
         wait_mod(16);
         bus.digit0 = tbl[i].nib;
         wait_mod(4);
         chk("decode", bus.seg, tbl[i].seg);
      end

      // Mid-slot change on digit 1
      wait_mod(20);  bus.digit1 = 4'h5;
      wait_mod(13);  bus.digit1 = 4'h8;
      wait_mod(15);  chk("midslot_hold", bus.seg, 7'h12);
      wait_mod(12);  chk("midslot_next", bus.seg, 7'h00);

      // Disable and decimal point
      wait_mod(31);  bus.digit_en = 4'b1010; bus.dp_in = 4'b0010;
      wait_mod(4);   chk("dis0_an", bus.an, 4'b1111); chk("dis0_seg", bus.seg, 7'h7F);
      wait_mod(12);  chk("en1_an", bus.an, 4'b1101);  chk("en1_dp", bus.dp, 1'b0);
      wait_mod(20);  chk("dis2_an", bus.an, 4'b1111); chk("dis2_dp", bus.dp, 1'b1);
      wait_mod(28);  chk("en3_an", bus.an, 4'b0111);  chk("en3_dp", bus.dp, 1'b1);
      wait_mod(12);  chk("en1_period", bus.an, 4'b1101);

      // Asynchronous reset mid-SHOW of digit 2
      wait_mod(31);  bus.digit_en = 4'b1111; bus.dp_in = 4'b0000;
      wait_mod(20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_an", bus.an, 4'b1111);
      chk("async_idx", bus.scan_idx, 2'd0);
      chk("async_seg", bus.seg, 7'h7F);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_e(2);  chk("rel_e2_an", bus.an, 4'b1111);
      wait_e(3);  chk("rel_e3_an", bus.an, 4'b1110);

      // Random soak: scoreboard checks every cycle
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         bus.digit0   = 4'($urandom);
         bus.digit1   = 4'($urandom);
         bus.digit2   = 4'($urandom);
         bus.digit3   = 4'($urandom);
         bus.digit_en = 4'($urandom);
         bus.dp_in    = 4'($urandom);
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
